// File: rtl/taxi_apb_if.sv
// taxi_apb_if: APB bus bundle with requester and completer views
interface taxi_apb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int STRB_W = DATA_W/8,
   parameter int PAUSER_W = 1,
   parameter int PWUSER_W = 1,
   parameter int PRUSER_W = 1,
   parameter int PBUSER_W = 1
);
   logic [ADDR_W-1:0] paddr;
   logic [2:0] pprot;
   logic psel;
   logic penable;
   logic pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [STRB_W-1:0] pstrb;
   logic [PAUSER_W-1:0] pauser;
   logic [PWUSER_W-1:0] pwuser;
   logic pready;
   logic [DATA_W-1:0] prdata;
   logic pslverr;
   logic [PRUSER_W-1:0] pruser;
   logic [PBUSER_W-1:0] pbuser;

   modport mst (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
      input pready, prdata, pslverr, pruser, pbuser
   );

   modport slv (
      input paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
      output pready, prdata, pslverr, pruser, pbuser
   );
endinterface

// File: rtl/taxi_apb_ram.sv
// taxi_apb_ram: APB completer backed by byte-strobed RAM with wait states and error responses
module taxi_apb_ram #(
   parameter int ADDR_W = 8,
   parameter int WAIT_CYCLES = 0,
   parameter bit SECURE_ONLY = 1'b0
) (
   input logic clk,
   input logic rst,
   taxi_apb_if.slv s_apb
);
   localparam int DATA_W = s_apb.DATA_W;
   localparam int STRB_W = s_apb.STRB_W;
   localparam int BUS_AW = s_apb.ADDR_W;
   localparam int OFFS = $clog2(STRB_W);

   if (OFFS + ADDR_W > BUS_AW) begin : g_chk_addr
      $fatal(1, "RAM address range does not fit in the bus address");
   end
   if (DATA_W / STRB_W != 8) begin : g_chk_lane
      $fatal(1, "byte lanes must be 8 bits wide");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic write_q, write_d;
   logic err_q, err_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic pready_q, pready_d;
   logic pslverr_q, pslverr_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic req, live_err, do_acc;
   logic acc_write, acc_err;
   logic [ADDR_W-1:0] acc_idx;
   logic [DATA_W-1:0] acc_wdata;
   logic [STRB_W-1:0] acc_strb;

   assign s_apb.pready = pready_q;
   assign s_apb.pslverr = pslverr_q;
   assign s_apb.prdata = prdata_q;
   assign s_apb.pruser = '0;
   assign s_apb.pbuser = '0;

   // next-state, capture and response computation; with no wait states the access uses live bus values
   always_comb begin
      req = s_apb.psel && s_apb.penable && !pready_q;
      live_err = (|(s_apb.paddr >> (OFFS + ADDR_W))) || (SECURE_ONLY && s_apb.pprot[1]);
      state_d = state_q;
      cnt_d = cnt_q;
      idx_d = idx_q;
      write_d = write_q;
      err_d = err_q;
      wdata_d = wdata_q;
      strb_d = strb_q;
      pready_d = 1'b0;
      pslverr_d = pslverr_q;
      prdata_d = prdata_q;
      do_acc = 1'b0;
      case (state_q)
         IDLE: if (req) begin
            idx_d = s_apb.paddr[OFFS +: ADDR_W];
            write_d = s_apb.pwrite;
            err_d = live_err;
            wdata_d = s_apb.pwdata;
            strb_d = s_apb.pstrb;
            cnt_d = 8'(WAIT_CYCLES);
            state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
            do_acc = WAIT_CYCLES == 0;
         end
         WAIT: begin
            cnt_d = cnt_q - 8'd1;
            state_d = !s_apb.psel ? IDLE : cnt_q == 8'd1 ? RESP : WAIT;
            do_acc = s_apb.psel && cnt_q == 8'd1;
         end
         default: state_d = IDLE;
      endcase
      acc_idx = state_q == IDLE ? s_apb.paddr[OFFS +: ADDR_W] : idx_q;
      acc_write = state_q == IDLE ? s_apb.pwrite : write_q;
      acc_err = state_q == IDLE ? live_err : err_q;
      acc_wdata = state_q == IDLE ? s_apb.pwdata : wdata_q;
      acc_strb = state_q == IDLE ? s_apb.pstrb : strb_q;
      if (do_acc) begin
         pready_d = 1'b1;
         pslverr_d = acc_err;
         prdata_d = acc_err ? '0 : mem[acc_idx];
      end
   end

   // state, captured request and registered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         idx_q <= '0;
         write_q <= 1'b0;
         err_q <= 1'b0;
         wdata_q <= '0;
         strb_q <= '0;
         pready_q <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         write_q <= write_d;
         err_q <= err_d;
         wdata_q <= wdata_d;
         strb_q <= strb_d;
         pready_q <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q <= prdata_d;
      end
   end

   // unreset storage; the write lands on the edge that raises pready
   always_ff @(posedge clk) begin
      if (do_acc && acc_write && !acc_err && !rst) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (acc_strb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_taxi_apb_ram.sv
// tb_taxi_apb_ram: randomized APB traffic checked against an array model of the RAM
module tb_taxi_apb_ram;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] ref_mem [256];
   logic [31:0] rd;
   logic er;

   taxi_apb_if #(.DATA_W(32), .ADDR_W(16)) apb ();

   taxi_apb_ram #(.ADDR_W(8), .WAIT_CYCLES(2), .SECURE_ONLY(1'b1)) dut (
      .clk(clk),
      .rst(rst),
      .s_apb(apb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      apb.psel = 1'b0;
      apb.penable = 1'b0;
   endtask

   task automatic xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p,
                       output logic [31:0] rdata, output logic err);
      logic exp_e;
      logic [31:0] exp_d;
      int lat;
      exp_e = (a >= 16'h0400) || p[1];
      exp_d = exp_e ? 32'h0 : ref_mem[a[9:2]];
      @(posedge clk); #1;
      apb.psel = 1'b1;
      apb.penable = 1'b0;
      apb.paddr = a;
      apb.pwrite = w;
      apb.pwdata = d;
      apb.pstrb = s;
      apb.pprot = p;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            apb.pwdata = ~d;
            apb.paddr = a ^ 16'h0004;
         end
      end while (!apb.pready && lat < 20);
      rdata = apb.prdata;
      err = apb.pslverr;
      check("latency", lat, 3);
      check("pslverr", err, exp_e);
      if (!w) check("prdata", rdata, exp_d);
      if (w && !exp_e)
         for (int i = 0; i < 4; i++) if (s[i]) ref_mem[a[9:2]][8*i +: 8] = d[8*i +: 8];
      bus_idle();
      @(posedge clk); #1;
      check("pready_pulse", apb.pready, 1'b0);
   endtask

   initial begin
      bus_idle();
      apb.paddr = '0;
      apb.pwrite = 1'b0;
      apb.pwdata = '0;
      apb.pstrb = '0;
      apb.pprot = '0;
      apb.pauser = '0;
      apb.pwuser = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pready", apb.pready, 1'b0);
      check("rst_pslverr", apb.pslverr, 1'b0);
      check("rst_prdata", apb.prdata, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) xfer(16'(i*4), 1'b1, 32'h0, 4'hF, 3'b000, rd, er);
      xfer(16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, rd, er);
      xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
      check("wr_rd", rd, 32'hDEADBEEF);
      xfer(16'h0020, 1'b1, 32'h11223344, 4'hF, 3'b000, rd, er);
      xfer(16'h0020, 1'b1, 32'hAABBCCDD, 4'h5, 3'b000, rd, er);
      xfer(16'h0020, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
      check("partial", rd, 32'h11BB33DD);
      xfer(16'h0000, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er);
      xfer(16'h0400, 1'b1, 32'h12345678, 4'hF, 3'b000, rd, er);
      check("unmapped_wr_err", er, 1'b1);
      xfer(16'h0000, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
      check("word0_kept", rd, 32'hA5A5A5A5);
      xfer(16'h0400, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
      check("unmapped_rd", {rd[30:0], er}, 32'h1);
      xfer(16'h0030, 1'b1, 32'h01020304, 4'hF, 3'b000, rd, er);
      xfer(16'h0030, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b010, rd, er);
      check("nonsec_err", er, 1'b1);
      xfer(16'h0030, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
      check("nonsec_kept", rd, 32'h01020304);
      xfer(16'h03FC, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, rd, er);
      xfer(16'h03FF, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
      check("last_word", rd, 32'hCAFEF00D);
      xfer(16'h0004, 1'b1, 32'h0BADF00D, 4'h0, 3'b000, rd, er);
      check("strb0_okay", er, 1'b0);
      for (int n = 0; n < 300; n++) begin
         int r;
         logic [15:0] a;
         logic [2:0] p;
         r = $urandom_range(0, 9);
         a = {6'(r == 0 ? $urandom_range(1, 63) : 0), 10'($urandom)};
         p = r == 1 ? 3'b010 : 3'($urandom) & 3'b101;
         xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), p, rd, er);
      end
      xfer(16'h0040, 1'b1, 32'h77665544, 4'hF, 3'b000, rd, er);
      @(posedge clk); #1;
      apb.psel = 1'b1;
      apb.paddr = 16'h0040;
      apb.pwrite = 1'b1;
      apb.pwdata = 32'h00000055;
      apb.pstrb = 4'hF;
      apb.pprot = 3'b000;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen |= apb.pready;
            if (i == 1) begin
               bus_idle();
               rst = 1'b0;
            end
         end
         check("rst_mid_no_pready", seen, 1'b0);
      end
      xfer(16'h0040, 1'b0, 32'h0, 4'h0, 3'b000, rd, er);
      check("rst_mid_kept", rd, 32'h77665544);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
